bus_master_arbiter: RTL
=======================

# bus_master_arbiter

Shared-bus arbiter and master multiplexer placed between the CPU's two bus masters (instruction fetch port and memory-access port) plus two further masters (DMA or debug) and the single slave-side bus. It grants exclusive bus ownership by registered round-robin with grant parking and no preemption. It routes the owner's address/control/write data onto the slave bus. A watchdog reports transactions whose `rdy_` never arrives.

## Interface
Parameters:
- `TIMEOUT`, 256: consecutive wait cycles before a timeout is reported; legal range 2..65535.
- `CNT_W`, 16: width of the watchdog counter; must satisfy 2^CNT_W >= TIMEOUT.

Ports:
- `clk` in 1: single system clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `m_req_` in 4: per-master bus request, active-low; bit i = master i (0 = IF port, 1 = MEM port).
- `m_addr` in 120: per-master word address; master i occupies bits [30i+29:30i].
- `m_as_` in 4: per-master address strobe, active-low.
- `m_rw` in 4: per-master direction, 1 = read, 0 = write.
- `m_wr_data` in 128: per-master write data; master i occupies bits [32i+31:32i].
- `m_grnt_` out 4: per-master grant, active-low, one-cold.
- `s_addr` out 30: slave-bus word address.
- `s_as_` out 1: slave-bus address strobe, active-low.
- `s_rw` out 1: slave-bus direction.
- `s_wr_data` out 32: slave-bus write data.
- `s_rdy_` in 1: slave ready, active-low. It is broadcast to masters outside this block.
- `bus_timeout` out 1: one-cycle pulse, watchdog expired.
- `timeout_id` out 2: owner index latched with the last `bus_timeout`.

## Operation
- State: `owner[1:0]`, watchdog `cnt[CNT_W-1:0]`, `bus_timeout`, `timeout_id`.
- Grant: `m_grnt_` is all ones except bit `owner`, which is 0. The grant is always parked on `owner`, including when nobody requests.
- Ownership held while `m_req_[owner]` = 0; no preemption.
- Arbitration at each edge when `m_req_[owner]` = 1:
  - Scan masters in the order `owner+1`, `owner+2`, `owner+3` (mod 4).
  - The first master with `m_req_` = 0 becomes the new `owner`.
  - If no master is requesting, `owner` is unchanged.
- Multiplexer (combinational from `owner`):
  - When `m_req_[owner]` = 0: `s_addr`/`s_as_`/`s_rw`/`s_wr_data` equal the owner's fields.
  - Otherwise the outputs are idle values: `s_addr` = 0, `s_as_` = 1, `s_rw` = 1, `s_wr_data` = 0.
- Watchdog, evaluated each edge:
  - If `s_as_` = 0 and `s_rdy_` = 1:
    - If `cnt` = TIMEOUT-1: `cnt` <= 0, `bus_timeout` <= 1, `timeout_id` <= `owner`.
    - Otherwise: `cnt` <= `cnt`+1, `bus_timeout` <= 0.
  - Otherwise: `cnt` <= 0, `bus_timeout` <= 0.
  - The watchdog is report-only. Ownership and bus outputs are not altered. A still-stalled transaction reports again every TIMEOUT cycles.
- Reset, asynchronous and taking effect immediately, including mid-transaction:
  - `owner` = 0, so `m_grnt_` = 4'b1110.
  - `cnt` = 0, `bus_timeout` = 0, `timeout_id` = 0.
  - Bus outputs take their idle values unless master 0 is requesting.

## Timing
- Grant latency from idle: a request seen at edge N (owner not requesting) gives `m_grnt_` low in the cycle after edge N. The first `s_as_` from that master can appear in the same cycle.
- Handover: the owner releases `m_req_` before edge N, and the new grant is visible after edge N. There are no dead cycles beyond this one registered decision. Only one grant is low in any cycle.
- Re-request: if the owner deasserts `m_req_` for a single sampled edge while others wait, it loses the bus at that edge.
- Simultaneous requests: the master nearest after the current owner in round-robin order wins. After reset, the order is 1, 2, 3, 0.
- Masters must hold `m_as_` low until `s_rdy_` = 0 and must not assert `m_as_` without a grant. The arbiter gates only on `m_req_`.
- Watchdog: `bus_timeout` is high in the cycle after the TIMEOUT-th consecutive edge sampling `s_as_` = 0 and `s_rdy_` = 1. An `s_rdy_` = 0 at any edge before that clears the count.

## Test plan
- Reset, then no requests: `m_grnt_` = 4'b1110, `s_as_` = 1, `s_addr` = 0, `bus_timeout` = 0.
- Master 1 requests alone:
  - Grant after one edge gives `m_grnt_` = 4'b1101.
  - Master 1 drives `m_addr` = 30'h0000_1234 with `m_as_` low: `s_addr` = 30'h0000_1234 and `s_as_` = 0.
- Masters 0, 2 and 3 all request while master 1 owns; master 1 releases:
  - Grants go to 2, then 3, then 0, each after its predecessor releases.
  - `m_grnt_` sequence: 1011, 0111, 1110.
- Owner 0 holds `m_req_` low for 10 cycles while master 3 requests: `m_grnt_` stays 4'b1110 for all 10 cycles. Grant moves to 3 on the edge after release.
- TIMEOUT = 4, master 2 owns, `s_as_` = 0, `s_rdy_` stuck at 1:
  - `bus_timeout` pulses exactly one cycle after the 4th waiting edge, with `timeout_id` = 2.
  - It pulses again 4 cycles later.
  - With `s_rdy_` = 0 on the 3rd edge, there is no pulse.
- Assert `reset` mid-transaction while master 3 owns with `cnt` = 2: `m_grnt_` = 4'b1110 and `cnt` = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter: four-master shared-bus arbiter with registered
// round-robin ownership, grant parking, an owner-driven slave-bus
// multiplexer and a report-only watchdog for transactions that never
// see a ready from the slave.
module bus_master_arbiter #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   m_req_,
  input  logic [119:0] m_addr,
  input  logic [3:0]   m_as_,
  input  logic [3:0]   m_rw,
  input  logic [127:0] m_wr_data,
  output logic [3:0]   m_grnt_,
  output logic [29:0]  s_addr,
  output logic         s_as_,
  output logic         s_rw,
  output logic [31:0]  s_wr_data,
  input  logic         s_rdy_,
  output logic         bus_timeout,
  output logic [1:0]   timeout_id
);

  // Per-master views of the flattened address and write-data buses;
  // element i lines up with bits [W*i+W-1 : W*i] of the flat port.
  logic [3:0][29:0] addr_v;
  logic [3:0][31:0] wdata_v;

  logic [1:0]       owner;
  logic [1:0]       next_owner;
  logic [1:0]       cand;
  logic             found;
  logic [CNT_W-1:0] cnt;
  logic             waiting;

  assign addr_v  = m_addr;
  assign wdata_v = m_wr_data;

  // The grant is parked on the owner at all times, so exactly one bit is low.
  assign m_grnt_ = ~(4'b0001 << owner);

  // A cycle counts toward the watchdog while a strobe is out and no ready came back.
  assign waiting = ~s_as_ & s_rdy_;

  // Round-robin pick: only when the owner has dropped its request, scan
  // owner+1..owner+3 and take the first requester; otherwise stay parked.
  always_comb begin
    next_owner = owner;
    found      = 1'b0;
    cand       = owner;
    if (m_req_[owner]) begin
      for (int k = 1; k < 4; k++) begin
        cand = owner + 2'(k);
        if (!found && !m_req_[cand]) begin
          next_owner = cand;
          found      = 1'b1;
        end
      end
    end
  end

  // Ownership register; reset parks the bus on master 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner <= 2'd0;
    end else begin
      owner <= next_owner;
    end
  end

  // Slave-bus mux: the owner's fields pass through only while it still
  // requests; otherwise the bus shows idle values.
  always_comb begin
    s_addr    = '0;
    s_as_     = 1'b1;
    s_rw      = 1'b1;
    s_wr_data = '0;
    if (!m_req_[owner]) begin
      s_addr    = addr_v[owner];
      s_as_     = m_as_[owner];
      s_rw      = m_rw[owner];
      s_wr_data = wdata_v[owner];
    end
  end

  // Watchdog: count consecutive waiting edges, pulse and record the owner
  // on the TIMEOUT-th, then restart so a stuck transfer reports repeatedly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      bus_timeout <= 1'b0;
      timeout_id  <= 2'd0;
    end else if (waiting) begin
      if (cnt == CNT_W'(TIMEOUT - 1)) begin
        cnt         <= '0;
        bus_timeout <= 1'b1;
        timeout_id  <= owner;
      end else begin
        cnt         <= cnt + 1'b1;
        bus_timeout <= 1'b0;
      end
    end else begin
      cnt         <= '0;
      bus_timeout <= 1'b0;
    end
  end

endmodule
